// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, x/y counters, syncs, strobes.
// Ports: clk, rst (async, active-low) in; pix_stb, x, y, active_pixels,
//   hsync, vsync, line_start, frame_start out.
// Optional macro VGA_FRAME_CNT_EN adds output frame_cnt[15:0].
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_stb,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active_pixels,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_cnt;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       wrap_x;
  logic       at_origin;

  assign pix_stb = (div_cnt == DIV_LAST);

  // Registered outputs are computed from the next coordinates so they
  // line up with x/y on the same edge.
  always_comb begin
    wrap_x    = (x == H_LAST);
    x_nxt     = wrap_x ? 10'd0 : x + 10'd1;
    y_nxt     = y;
    if (wrap_x) begin
      y_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
    end
    at_origin = (x_nxt == 10'd0) && (y_nxt == 10'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= 4'd0;
    end else if (pix_stb) begin
      div_cnt <= 4'd0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x             <= H_LAST;
      y             <= V_LAST;
      active_pixels <= 1'b0;
      hsync         <= ~SYNC_POL;
      vsync         <= ~SYNC_POL;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
    end else if (pix_stb) begin
      x             <= x_nxt;
      y             <= y_nxt;
      active_pixels <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
      hsync         <= (x_nxt >= HS_ON && x_nxt < HS_OFF)
                       ? SYNC_POL : ~SYNC_POL;
      vsync         <= (y_nxt >= VS_ON && y_nxt < VS_OFF)
                       ? SYNC_POL : ~SYNC_POL;
      line_start    <= (x_nxt == 10'd0);
      frame_start   <= at_origin;
    end else begin
      // Strobes last one clk even when a pixel spans several clks.
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= 16'd0;
    end else if (pix_stb && at_origin) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three geometries, per-clk model
// pushed on each edge and compared half a cycle later.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        stb;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        act;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_rec(input string p, input rec_t o, input rec_t e);
    check({p, ".stb"}, 32'(o.stb), 32'(e.stb));
    check({p, ".x"},   32'(o.x),   32'(e.x));
    check({p, ".y"},   32'(o.y),   32'(e.y));
    check({p, ".act"}, 32'(o.act), 32'(e.act));
    check({p, ".hs"},  32'(o.hs),  32'(e.hs));
    check({p, ".vs"},  32'(o.vs),  32'(e.vs));
    check({p, ".ls"},  32'(o.ls),  32'(e.ls));
    check({p, ".fs"},  32'(o.fs),  32'(e.fs));
`ifdef VGA_FRAME_CNT_EN
    check({p, ".fc"},  32'(o.fc),  32'(e.fc));
`endif
  endtask

  // Expected state after n rising edges since reset release.
  function automatic rec_t model(int n, int dv,
                                 int ha, int hf, int hw, int hb,
                                 int va, int vf, int vw, int vb,
                                 bit pol);
    rec_t r;
    int ht = ha + hf + hw + hb;
    int vt = va + vf + vw + vb;
    int a  = n / dv;
    int k, px, py;
    r.stb = ((n % dv) == dv - 1);
    if (a == 0) begin
      px = ht - 1;
      py = vt - 1;
    end else begin
      k  = (a - 1) % (ht * vt);
      px = k % ht;
      py = k / ht;
    end
    r.x   = 10'(px);
    r.y   = 10'(py);
    r.act = (a > 0) && (px < ha) && (py < va);
    r.hs  = (px >= ha + hf && px < ha + hf + hw) ? pol : ~pol;
    r.vs  = (py >= va + vf && py < va + vf + vw) ? pol : ~pol;
    r.ls  = (a > 0) && ((n % dv) == 0) && (px == 0);
    r.fs  = r.ls && (py == 0);
    r.fc  = (a == 0) ? 16'd0 : 16'((a - 1) / (ht * vt) + 1);
    return r;
  endfunction

  // Instance A: small geometry, CLK_DIV=2, active-low syncs
  logic a_stb, a_act, a_hs, a_vs, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [15:0] a_fc;
  // Instance B: full 640x480 geometry, defaults
  logic b_stb, b_act, b_hs, b_vs, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [15:0] b_fc;
  // Instance C: small geometry, CLK_DIV=1, active-high syncs
  logic c_stb, c_act, c_hs, c_vs, c_ls, c_fs;
  logic [9:0] c_x, c_y;
  logic [15:0] c_fc;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(2), .SYNC_POL(1'b0)
  ) u_a (
    .clk(clk), .rst(rst), .pix_stb(a_stb), .x(a_x), .y(a_y),
    .active_pixels(a_act), .hsync(a_hs), .vsync(a_vs),
    .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_timing_gen u_b (
    .clk(clk), .rst(rst), .pix_stb(b_stb), .x(b_x), .y(b_y),
    .active_pixels(b_act), .hsync(b_hs), .vsync(b_vs),
    .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .CLK_DIV(1), .SYNC_POL(1'b1)
  ) u_c (
    .clk(clk), .rst(rst), .pix_stb(c_stb), .x(c_x), .y(c_y),
    .active_pixels(c_act), .hsync(c_hs), .vsync(c_vs),
    .line_start(c_ls), .frame_start(c_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(c_fc)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign a_fc = 16'd0;
  assign b_fc = 16'd0;
  assign c_fc = 16'd0;
`endif

  rec_t qa[$];
  rec_t qb[$];
  rec_t qc[$];
  int na = 0;
  int nb = 0;
  int nc = 0;

  // Stimulus side: each edge pushes what the DUT must show after it.
  always @(posedge clk) begin
    na = rst ? na + 1 : 0;
    nb = rst ? nb + 1 : 0;
    nc = rst ? nc + 1 : 0;
    qa.push_back(model(na, 2, 8, 2, 3, 2, 5, 2, 2, 3, 1'b0));
    qb.push_back(model(nb, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    qc.push_back(model(nc, 1, 6, 1, 2, 1, 4, 1, 1, 2, 1'b1));
  end

  always @(negedge clk) begin
    if (qa.size() > 0)
      cmp_rec("a", {a_stb, a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fs, a_fc},
              qa.pop_front());
    if (qb.size() > 0)
      cmp_rec("b", {b_stb, b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fs, b_fc},
              qb.pop_front());
    if (qc.size() > 0)
      cmp_rec("c", {c_stb, c_x, c_y, c_act, c_hs, c_vs, c_ls, c_fs, c_fc},
              qc.pop_front());
  end

  // Line statistics on the full-size instance
  bit b_seen = 0;
  int b_cnt = 0, b_act_c = 0, b_hs_c = 0;
  int b_per = 0, b_act_n = 0, b_hs_n = 0;

  always @(negedge clk) begin
    if (!rst) begin
      b_seen = 0;
    end else begin
      if (b_ls) begin
        if (b_seen && b_per == 0) begin
          b_per   = b_cnt;
          b_act_n = b_act_c;
          b_hs_n  = b_hs_c;
        end
        b_seen  = 1;
        b_cnt   = 0;
        b_act_c = 0;
        b_hs_c  = 0;
      end
      b_cnt++;
      if (b_act) b_act_c++;
      if (!b_hs) b_hs_c++;
    end
  end

  initial begin
    bit found;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2000) @(negedge clk);

    check("b.line_period", 32'(b_per), 32'd1600);
    check("b.active_clks", 32'(b_act_n), 32'd1280);
    check("b.hsync_clks",  32'(b_hs_n), 32'd192);

    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (a_x == 10'd4 && a_y == 10'd3) found = 1;
    end
    check("a.find_x4y3", 32'(found), 32'd1);

    #2 rst = 1'b0;
    #1;
    check("rst.a.x",   32'(a_x),   32'd14);
    check("rst.a.y",   32'(a_y),   32'd11);
    check("rst.a.act", 32'(a_act), 32'd0);
    check("rst.a.hs",  32'(a_hs),  32'd1);
    check("rst.a.vs",  32'(a_vs),  32'd1);
    check("rst.a.fs",  32'(a_fs),  32'd0);
    check("rst.b.x",   32'(b_x),   32'd799);
    check("rst.b.y",   32'(b_y),   32'd524);
    check("rst.c.hs",  32'(c_hs),  32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (800) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator for the 640x480@60 VGA display path. Produces the pixel coordinates and active flag consumed by the start-screen and game renderers, plus the hsync/vsync signals for the VGA DAC. Runs from the system clock and advances the raster once every CLK_DIV clocks. Also emits frame and line strobes for renderer state updates.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, clk cycles per pixel; 1..15
SYNC_POL, 0, asserted level of hsync/vsync

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
pix_stb  out  1  high in every clk cycle whose rising edge advances the raster
x  out  10  horizontal count 0..H_TOTAL-1
y  out  10  vertical count 0..V_TOTAL-1
active_pixels  out  1  1 when x<H_ACTIVE and y<V_ACTIVE
hsync  out  1  horizontal sync, SYNC_POL when asserted
vsync  out  1  vertical sync, SYNC_POL when asserted
line_start  out  1  one-clk pulse, first clk with x==0 (every line, including blanking lines)
frame_start  out  1  one-clk pulse, first clk with x==0 and y==0

Behaviour:
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider div_cnt runs 0..CLK_DIV-1 and wraps. pix_stb = (div_cnt==CLK_DIV-1); with CLK_DIV=1 it is constantly 1.
- On an edge with pix_stb=1:
  - x increments; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps from V_TOTAL-1 to 0.
  - Counters are otherwise held.
- All outputs except pix_stb are registers updated on the same edge as x/y, so they always describe the current x/y (zero skew):
  - active_pixels: as defined under Ports.
  - hsync = SYNC_POL for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~SYNC_POL.
  - vsync = SYNC_POL for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise ~SYNC_POL.
- line_start/frame_start are high only in the single clk immediately after the advancing edge. With CLK_DIV>1 they are low for the remaining clks of that pixel.
- Reset (rst=0, asynchronous): div_cnt=0, x=H_TOTAL-1, y=V_TOTAL-1, active_pixels=0, hsync=vsync=~SYNC_POL, line_start=frame_start=0. The first advance after release therefore wraps to (0,0) and fires frame_start.
- Reset asserted mid-frame returns immediately to the reset state. No partial-frame recovery.
- Release: the first advance occurs at the CLK_DIV-th rising edge after rst deasserts.

Optional Feature:
VGA_FRAME_CNT_EN
- Defined: adds output frame_cnt [15:0]. Reset to 0; increments (wrapping at 0xFFFF) on the same edge that raises frame_start. Provides timebase for blink/animation.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, CLK_DIV=2, release rst -> pix_stb toggles 0,1,...; after 2nd edge x=0,y=0, active_pixels=1, frame_start and line_start high for exactly 1 clk.
- Run one line -> x cycles 0..799, line period 1600 clks; active_pixels high 1280 clks/line; hsync=0 exactly for x=656..751 (192 clks).
- Run full frame -> frame_start period 840000 clks; vsync=0 only for y=490..491 (3200 clks); active_pixels high 614400 clks; y wraps 524->0 with x 799->0.
- Assert rst at x=300,y=200 for 3 clks -> outputs immediately x=799,y=524, syncs=1, active=0; after release, the frame restarts with frame_start.
- CLK_DIV=1, SYNC_POL=1 -> pix_stb constant 1, line period 800 clks, hsync=1 only for x=656..751.
- With VGA_FRAME_CNT_EN defined, run 3 frames from reset -> frame_cnt reads 1,2,3 at successive frame_start pulses.
